wb_commit_trace: RTL

//   Consumer end of the writeback/commit interface: captures each instruction retired out of
//   the MEM/WB register (PC, instr, GPR write, LLbit write) and buffers it in a FIFO.

---
 rtl/wb_commit_trace_pkg.sv | 36 +++
 rtl/wb_commit_trace_sync_fifo.sv | 61 ++++++
 rtl/wb_commit_trace.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_commit_trace_pkg.sv
// Shared trace entry layout (TraceEntryBus) for the commit trace buffer and the difftest bridge.
// Fields are packed LSB first: llbit, llbit_we, wdata, wdest, wen, instr, pc.
package wb_commit_trace_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REGA_W = 5;

  localparam int TE_OFF_LLBIT    = 0;
  localparam int TE_OFF_LLBIT_WE = 1;
  localparam int TE_OFF_WDATA    = 2;

  function automatic int te_off_wdest(int data_w);
    return TE_OFF_WDATA + data_w;
  endfunction

  function automatic int te_off_wen(int data_w, int rega_w);
    return te_off_wdest(data_w) + rega_w;
  endfunction

  function automatic int te_off_instr(int data_w, int rega_w);
    return te_off_wen(data_w, rega_w) + 1;
  endfunction

  function automatic int te_off_pc(int data_w, int rega_w);
    return te_off_instr(data_w, rega_w) + data_w;
  endfunction

  function automatic int te_width(int addr_w, int data_w, int rega_w);
    return te_off_pc(data_w, rega_w) + addr_w;
  endfunction

  localparam int TRACE_ENTRY_W = te_width(DEF_ADDR_W, DEF_DATA_W, DEF_REGA_W);

endpackage

// File: rtl/wb_commit_trace_sync_fifo.sv
// Level-tracked synchronous FIFO; full/empty derive from the occupancy count, pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = level_q;

  always_comb begin
    level_next = level_q;
    if (do_push && !do_pop)
      level_next = level_q + LVL_W'(1);
    else if (!do_push && do_pop)
      level_next = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_next;
    end
  end

endmodule

// File: rtl/wb_commit_trace.sv
// Commit trace buffer: normalises retirements from MEM/WB, queues them for the trace sink,
// counts accepted retirements and flags any that had to be dropped.
module wb_commit_trace
  import wb_commit_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REGA_W = DEF_REGA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_commit_valid,
  input  logic [ADDR_W-1:0]       wb_commit_pc,
  input  logic [DATA_W-1:0]       wb_commit_instr,
  input  logic                    wb_wreg,
  input  logic [REGA_W-1:0]       wb_wd,
  input  logic [DATA_W-1:0]       wb_wdata,
  input  logic                    wb_LLbit_we,
  input  logic                    wb_LLbit_value,
  input  logic                    ovf_clr,
  input  logic                    trace_ready,
  output logic                    trace_valid,
  output logic [ADDR_W-1:0]       trace_pc,
  output logic [DATA_W-1:0]       trace_instr,
  output logic                    trace_wen,
  output logic [REGA_W-1:0]       trace_wdest,
  output logic [DATA_W-1:0]       trace_wdata,
  output logic                    trace_llbit_we,
  output logic                    trace_llbit,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  level,
  output logic [63:0]             commit_count,
  output logic                    overflow
);

  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam int ENTRY_W   = te_width(ADDR_W, DATA_W, REGA_W);
  localparam int OFF_WDEST = te_off_wdest(DATA_W);
  localparam int OFF_WEN   = te_off_wen(DATA_W, REGA_W);
  localparam int OFF_INSTR = te_off_instr(DATA_W, REGA_W);
  localparam int OFF_PC    = te_off_pc(DATA_W, REGA_W);

  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   level_next;
  logic               pop;
  logic               push;
  logic               drop;
  logic               norm_wen;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [63:0]        commit_count_q;

  assign trace_valid = !fifo_empty;
  assign pop         = trace_valid && trace_ready;
  assign push        = wb_commit_valid && (!fifo_full || pop);
  assign drop        = wb_commit_valid && fifo_full && !pop;

  // Writes to r0 are architecturally invisible, so they are recorded as no-writes.
  assign norm_wen   = wb_wreg && (wb_wd != '0);
  assign push_entry = {wb_commit_pc,
                       wb_commit_instr,
                       norm_wen,
                       norm_wen ? wb_wd : {REGA_W{1'b0}},
                       norm_wen ? wb_wdata : {DATA_W{1'b0}},
                       wb_LLbit_we,
                       wb_LLbit_we & wb_LLbit_value};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      (push_entry),
    .rdata      (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level),
    .level_next (level_next)
  );

  assign trace_pc       = head_entry[OFF_PC +: ADDR_W];
  assign trace_instr    = head_entry[OFF_INSTR +: DATA_W];
  assign trace_wen      = head_entry[OFF_WEN];
  assign trace_wdest    = head_entry[OFF_WDEST +: REGA_W];
  assign trace_wdata    = head_entry[TE_OFF_WDATA +: DATA_W];
  assign trace_llbit_we = head_entry[TE_OFF_LLBIT_WE];
  assign trace_llbit    = head_entry[TE_OFF_LLBIT];
  assign commit_count   = commit_count_q;

  // Stall two entries early: up to two retirements may already be past the stall point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_count_q <= '0;
      overflow       <= 1'b0;
      stall_req      <= 1'b0;
    end else begin
      if (push)
        commit_count_q <= commit_count_q + 64'd1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      stall_req <= (level_next >= LVL_W'(DEPTH - 2));
    end
  end

endmodule
